// File: rtl/uart_rx_frame.sv
// UART receiver: 1 start, 8 data (LSB first), 1 parity, 1 stop. Returns the byte plus parity/framing status.
// Optional build macro UART_RX_MAJORITY_EN: each sample point becomes a 2-of-3 vote around the bit centre.
module uart_rx_frame #(
  parameter int counter_ceil_rec = 2604,
  parameter bit PARITY_ODD       = 1'b0
) (
  input  logic       CLOCK_125_p,
  input  logic       rst_n,
  input  logic       Rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(counter_ceil_rec + 1);

`ifdef UART_RX_MAJORITY_EN
  // Decisions are taken one clock after the nominal point, once the third vote is in.
  localparam logic [CW-1:0] START_TC = CW'(counter_ceil_rec / 2);
  localparam logic [CW-1:0] BIT_TC   = CW'(counter_ceil_rec);
`else
  localparam logic [CW-1:0] START_TC = CW'(counter_ceil_rec / 2 - 1);
  localparam logic [CW-1:0] BIT_TC   = CW'(counter_ceil_rec - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    sr_reg, sr_next;
  logic          perr_reg, perr_next;
  logic [7:0]    data_out_reg, data_out_next;
  logic          data_valid_reg, data_valid_next;
  logic          parity_err_reg, parity_err_next;
  logic          frame_err_reg, frame_err_next;
  logic [1:0]    sync_reg;
  logic          rx_s;
  logic          sample;

  assign rx_s = sync_reg[1];

`ifdef UART_RX_MAJORITY_EN
  // hist_reg[0] holds rx_s at the point, hist_reg[1] at point-1; live rx_s is point+1.
  logic [1:0] hist_reg;

  always_ff @(posedge CLOCK_125_p) begin
    if (!rst_n) begin
      hist_reg <= 2'b11;
    end else begin
      hist_reg <= {hist_reg[0], rx_s};
    end
  end

  assign sample = (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & rx_s) | (hist_reg[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge CLOCK_125_p) begin
    if (!rst_n) begin
      sync_reg       <= 2'b11;
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      bit_reg        <= '0;
      sr_reg         <= '0;
      perr_reg       <= 1'b0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[0], Rx};
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bit_reg        <= bit_next;
      sr_reg         <= sr_next;
      perr_reg       <= perr_next;
      data_out_reg   <= data_out_next;
      data_valid_reg <= data_valid_next;
      parity_err_reg <= parity_err_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg + 1'b1;
    bit_next        = bit_reg;
    sr_next         = sr_reg;
    perr_next       = perr_reg;
    data_out_next   = data_out_reg;
    data_valid_next = 1'b0;
    parity_err_next = parity_err_reg;
    frame_err_next  = frame_err_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) begin
          state_next = START;
        end
      end
      START: begin
        if (cnt_reg == START_TC) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = sample ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_reg == BIT_TC) begin
          cnt_next         = '0;
          sr_next[bit_reg] = sample;
          bit_next         = bit_reg + 1'b1;
          if (bit_reg == 3'd7) begin
            state_next = PARITY;
          end
        end
      end
      PARITY: begin
        if (cnt_reg == BIT_TC) begin
          cnt_next   = '0;
          perr_next  = ((^sr_reg) ^ sample) != PARITY_ODD;
          state_next = STOP;
        end
      end
      STOP: begin
        if (cnt_reg == BIT_TC) begin
          cnt_next        = '0;
          data_out_next   = sr_reg;
          parity_err_next = perr_reg;
          frame_err_next  = ~sample;
          data_valid_next = 1'b1;
          // A low stop bit may be a break; wait for the line to recover before rearming.
          state_next      = sample ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        cnt_next = '0;
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 16 clocks per bit, even parity.
// Follows the DUT build: define UART_RX_MAJORITY_EN here too when the DUT is built with voting.
module tb_uart_rx_frame;
  localparam int N = 16;
`ifdef UART_RX_MAJORITY_EN
  // The voting receiver spends N+1 clocks per bit, so the transmitter is matched to it.
  localparam int BT  = N + 1;
  localparam int LAT = 171 + 11;
  localparam bit GLITCH = 1'b1;
`else
  localparam int BT  = N;
  localparam int LAT = 171;
  localparam bit GLITCH = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       Rx    = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int valid_cyc = 0;
  int frame_c0 = 0;

  uart_rx_frame #(
    .counter_ceil_rec(N),
    .PARITY_ODD(1'b0)
  ) dut (
    .CLOCK_125_p(clk),
    .rst_n(rst_n),
    .Rx(Rx),
    .data_out(data_out),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      pulse_cnt++;
      valid_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame slots: start, d0..d7, parity, stop. Optional 1-clock inversion mid-way through each data bit.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit glitch);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    frame_c0 = cyc;
    for (int i = 0; i < 11; i++) begin
      Rx = bits[i];
      if (glitch && i >= 1 && i <= 8) begin
        tick(BT / 2);
        Rx = ~bits[i];
        tick(1);
        Rx = bits[i];
        tick(BT - BT / 2 - 1);
      end else begin
        tick(BT);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    Rx    = 1'b1;
    tick(2);
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
    n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    tick(5);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b expected 0", busy); end
    $display("reset: data_out=%h valid=%b perr=%b ferr=%b busy=%b", data_out, data_valid, parity_err, frame_err, busy);
  endtask

  task automatic test_good_frame;
    int lat;
    pulse_cnt = 0;
    send_frame(8'hB3, 1'b1, 1'b1, 1'b0);
    lat = valid_cyc - frame_c0;
    n_cmp++; if (pulse_cnt !== 1) begin n_bad++; $display("FAIL good_pulses: got %0d expected 1", pulse_cnt); end
    n_cmp++; if (data_out !== 8'hB3) begin n_bad++; $display("FAIL good_data: got %h expected b3", data_out); end
    n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL good_parity_err: got %b expected 0", parity_err); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL good_frame_err: got %b expected 0", frame_err); end
    n_cmp++; if (lat < LAT - 1 || lat > LAT + 1) begin n_bad++; $display("FAIL good_latency: got %0d expected %0d+-1", lat, LAT); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL good_busy_after: got %b expected 0", busy); end
    $display("frame b3/p1/s1: data_out=%h perr=%b ferr=%b pulses=%0d latency=%0d", data_out, parity_err, frame_err, pulse_cnt, lat);
    tick(4);
  endtask

  task automatic test_parity_error;
    pulse_cnt = 0;
    send_frame(8'hB3, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (pulse_cnt !== 1) begin n_bad++; $display("FAIL perr_pulses: got %0d expected 1", pulse_cnt); end
    n_cmp++; if (data_out !== 8'hB3) begin n_bad++; $display("FAIL perr_data: got %h expected b3", data_out); end
    n_cmp++; if (parity_err !== 1'b1) begin n_bad++; $display("FAIL perr_parity_err: got %b expected 1", parity_err); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL perr_frame_err: got %b expected 0", frame_err); end
    $display("frame b3/p0/s1: data_out=%h perr=%b ferr=%b pulses=%0d", data_out, parity_err, frame_err, pulse_cnt);
    tick(4);
  endtask

  task automatic test_frame_error;
    pulse_cnt = 0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    tick(48);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL break_busy: got %b expected 1", busy); end
    Rx = 1'b1;
    tick(4);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL break_release_busy: got %b expected 0", busy); end
    n_cmp++; if (pulse_cnt !== 1) begin n_bad++; $display("FAIL break_pulses: got %0d expected 1", pulse_cnt); end
    n_cmp++; if (data_out !== 8'h5A) begin n_bad++; $display("FAIL break_data: got %h expected 5a", data_out); end
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL break_frame_err: got %b expected 1", frame_err); end
    $display("frame 5a/p0/s0+break: data_out=%h perr=%b ferr=%b pulses=%0d", data_out, parity_err, frame_err, pulse_cnt);
    pulse_cnt = 0;
    send_frame(8'h0F, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (pulse_cnt !== 1) begin n_bad++; $display("FAIL recover_pulses: got %0d expected 1", pulse_cnt); end
    n_cmp++; if (data_out !== 8'h0F) begin n_bad++; $display("FAIL recover_data: got %h expected 0f", data_out); end
    n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL recover_parity_err: got %b expected 0", parity_err); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL recover_frame_err: got %b expected 0", frame_err); end
    $display("frame 0f/p0/s1: data_out=%h perr=%b ferr=%b pulses=%0d", data_out, parity_err, frame_err, pulse_cnt);
    tick(4);
  endtask

  task automatic test_glitch;
    pulse_cnt = 0;
    Rx = 1'b0;
    tick(5);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_high: got %b expected 1", busy); end
    Rx = 1'b1;
    tick(7);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_fall: got %b expected 0", busy); end
    tick(2 * BT);
    n_cmp++; if (pulse_cnt !== 0) begin n_bad++; $display("FAIL glitch_pulses: got %0d expected 0", pulse_cnt); end
    $display("glitch 5 clocks: busy=%b pulses=%0d", busy, pulse_cnt);
  endtask

  task automatic test_reset_mid_frame;
    pulse_cnt = 0;
    Rx = 1'b0;
    tick(BT);
    Rx = 1'b1;
    tick(4 * BT + BT / 2);
    rst_n = 1'b0;
    tick(1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL midreset_data: got %h expected 00", data_out); end
    rst_n = 1'b1;
    tick(3 * BT);
    n_cmp++; if (pulse_cnt !== 0) begin n_bad++; $display("FAIL midreset_pulses: got %0d expected 0", pulse_cnt); end
    $display("reset during ff bit 4: busy=%b pulses=%0d", busy, pulse_cnt);
    send_frame(8'h5A, 1'b0, 1'b1, GLITCH);
    n_cmp++; if (pulse_cnt !== 1) begin n_bad++; $display("FAIL after_reset_pulses: got %0d expected 1", pulse_cnt); end
    n_cmp++; if (data_out !== 8'h5A) begin n_bad++; $display("FAIL after_reset_data: got %h expected 5a", data_out); end
    n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL after_reset_parity_err: got %b expected 0", parity_err); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL after_reset_frame_err: got %b expected 0", frame_err); end
    $display("frame 5a/p0/s1 glitch=%b: data_out=%h perr=%b ferr=%b pulses=%0d", GLITCH, data_out, parity_err, frame_err, pulse_cnt);
    tick(4);
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_parity_error;
    test_frame_error;
    test_glitch;
    test_reset_mid_frame;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
